// File: rtl/jk_seq_pkg.sv
// Shared opcode/state types and constants for the JK bank sequencer.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_SET  = 3'd1,
    OP_CLR  = 3'd2,
    OP_TOG  = 3'd3,
    OP_LOAD = 3'd4,
    OP_INC  = 3'd5,
    OP_SHL  = 3'd6,
    OP_RSVD = 3'd7
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } jk_state_e;

  localparam logic [2:0] OPC_NOP  = 3'd0;
  localparam logic [2:0] OPC_SET  = 3'd1;
  localparam logic [2:0] OPC_CLR  = 3'd2;
  localparam logic [2:0] OPC_TOG  = 3'd3;
  localparam logic [2:0] OPC_LOAD = 3'd4;
  localparam logic [2:0] OPC_INC  = 3'd5;
  localparam logic [2:0] OPC_SHL  = 3'd6;
  localparam logic [2:0] OPC_RSVD = 3'd7;

  // INC and SHL are the only opcodes that run for more than one EXEC cycle
  function automatic logic is_multi_step(input jk_op_e op);
    return (op == OP_INC) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command/status bundle between a command source and jk_bank_sequencer.
// cmd_abort exists only when JK_SEQ_ABORT_EN is defined.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
`ifdef JK_SEQ_ABORT_EN
  logic             cmd_abort;
`endif
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_count,
`ifdef JK_SEQ_ABORT_EN
    output cmd_abort,
`endif
    input  cmd_ready,
    input  q,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_count,
`ifdef JK_SEQ_ABORT_EN
    input  cmd_abort,
`endif
    output cmd_ready,
    output q,
    output busy,
    output done
  );

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK cells (bit ops, INC, SHL).
// Optional abort input enabled by defining JK_SEQ_ABORT_EN.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  jk_bank_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] STEP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  jk_state_e        state;
  jk_state_e        state_nxt;
  jk_op_e           op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] steps_left;

  logic             accept;
  logic             step_en;
  logic             abort;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] shl_j;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_r       <= OP_NOP;
      data_r     <= '0;
      steps_left <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r       <= jk_op_e'(bus.cmd_op);
        data_r     <= bus.cmd_data;
        steps_left <= bus.cmd_count;
      end else if (step_en) begin
        steps_left <= steps_left - STEP_ONE;
      end
    end
  end

  // Counter toggles ride a carry chain; shift drives each cell to its lower neighbour's value
  always_comb begin
    logic carry;
    carry = 1'b1;
    inc_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc_t[i] = carry;
      carry    = carry & q_bank[i];
    end
    shl_j = {q_bank[WIDTH-2:0], data_r[0]};
  end

  always_comb begin
    abort = 1'b0;
`ifdef JK_SEQ_ABORT_EN
    abort = bus.cmd_abort;
`endif
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    j         = '0;
    k         = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_DONE;
        if (abort) begin
          j = '0;
          k = '0;
        end else if (is_multi_step(op_r)) begin
          if (steps_left != '0) begin
            step_en = 1'b1;
            if (op_r == OP_INC) begin
              j = inc_t;
              k = inc_t;
            end else begin
              j = shl_j;
              k = ~shl_j;
            end
            if (steps_left != STEP_ONE) begin
              state_nxt = ST_EXEC;
            end
          end
        end else begin
          unique case (op_r)
            OP_SET: begin
              j = data_r;
            end
            OP_CLR: begin
              k = data_r;
            end
            OP_TOG: begin
              j = data_r;
              k = data_r;
            end
            OP_LOAD: begin
              j = data_r;
              k = ~data_r;
            end
            default: begin
              j = '0;
              k = '0;
            end
          endcase
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q_bank[i])
    );
  end

  assign bus.q         = q_bank;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed self-checking bench for jk_bank_sequencer (abort case under JK_SEQ_ABORT_EN).
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  jk_bank_sequencer_if #(.WIDTH(8), .CNT_W(8)) bus ();

  jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single edge; returns just after the accept edge
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data, input logic [7:0] count);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = count;
    stepClock();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic runSingle(input string tag, input logic [2:0] op, input logic [7:0] data, input logic [7:0] exp_q);
    applyStimulus(op, data, 8'd0);
    checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    stepClock();
    checkOutput({tag, "_q"}, {24'd0, bus.q}, {24'd0, exp_q});
    checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    stepClock();
    checkOutput({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput({tag, "_done_off"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic runMulti(input string tag, input logic [2:0] op, input logic [7:0] data,
                          input logic [7:0] count, input logic [7:0] exp_seq []);
    applyStimulus(op, data, count);
    for (int s = 0; s < exp_seq.size(); s++) begin
      stepClock();
      checkOutput($sformatf("%s_q%0d", tag, s), {24'd0, bus.q}, {24'd0, exp_seq[s]});
      checkOutput($sformatf("%s_done%0d", tag, s), {31'd0, bus.done},
                  (s == exp_seq.size() - 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s_busy%0d", tag, s), {31'd0, bus.busy}, 32'd1);
    end
    stepClock();
    checkOutput({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] seq [];
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OPC_NOP;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
`ifdef JK_SEQ_ABORT_EN
    bus.cmd_abort = 1'b0;
`endif
    stepClock();
    stepClock();
    rst = 1'b0;
    checkOutput("rst_q", {24'd0, bus.q}, 32'h0);
    checkOutput("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);

    runSingle("load_a5", OPC_LOAD, 8'hA5, 8'hA5);
    runSingle("tog_0f", OPC_TOG, 8'h0F, 8'hAA);
    runSingle("set_40", OPC_SET, 8'h40, 8'hEA);
    runSingle("clr_80", OPC_CLR, 8'h80, 8'h6A);
    runSingle("nop", OPC_NOP, 8'hFF, 8'h6A);
    runSingle("rsvd", OPC_RSVD, 8'hFF, 8'h6A);

    runSingle("load_fd", OPC_LOAD, 8'hFD, 8'hFD);
    seq = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    runMulti("inc5", OPC_INC, 8'h00, 8'd5, seq);

    runSingle("load_81", OPC_LOAD, 8'h81, 8'h81);
    seq = '{8'h03, 8'h07, 8'h0F};
    runMulti("shl3", OPC_SHL, 8'h01, 8'd3, seq);
    seq = '{8'h0F};
    runMulti("inc0", OPC_INC, 8'h00, 8'd0, seq);

    runSingle("load_33", OPC_LOAD, 8'h33, 8'h33);
    applyStimulus(OPC_INC, 8'h00, 8'd10);
    stepClock();
    checkOutput("inc10_q1", {24'd0, bus.q}, 32'h34);
    rst = 1'b1;
    stepClock();
    checkOutput("midrst_q", {24'd0, bus.q}, 32'h0);
    checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    stepClock();
    checkOutput("postrst_q", {24'd0, bus.q}, 32'h0);
    checkOutput("postrst_done", {31'd0, bus.done}, 32'd0);

    // Valid held through busy: the second payload must wait for IDLE
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OPC_LOAD;
    bus.cmd_data  = 8'h11;
    bus.cmd_count = 8'd0;
    stepClock();
    bus.cmd_data = 8'h77;
    stepClock();
    checkOutput("hold_q1", {24'd0, bus.q}, 32'h11);
    checkOutput("hold_done", {31'd0, bus.done}, 32'd1);
    stepClock();
    checkOutput("hold_q2", {24'd0, bus.q}, 32'h11);
    checkOutput("hold_ready", {31'd0, bus.cmd_ready}, 32'd1);
    stepClock();
    bus.cmd_valid = 1'b0;
    checkOutput("hold_accept", {31'd0, bus.busy}, 32'd1);
    checkOutput("hold_q3", {24'd0, bus.q}, 32'h11);
    stepClock();
    checkOutput("hold_q4", {24'd0, bus.q}, 32'h77);
    stepClock();

`ifdef JK_SEQ_ABORT_EN
    runSingle("load_00", OPC_LOAD, 8'h00, 8'h00);
    applyStimulus(OPC_INC, 8'h00, 8'd8);
    stepClock();
    checkOutput("abort_q1", {24'd0, bus.q}, 32'h01);
    stepClock();
    checkOutput("abort_q2", {24'd0, bus.q}, 32'h02);
    bus.cmd_abort = 1'b1;
    stepClock();
    bus.cmd_abort = 1'b0;
    checkOutput("abort_q3", {24'd0, bus.q}, 32'h02);
    checkOutput("abort_done", {31'd0, bus.done}, 32'd1);
    stepClock();
    checkOutput("abort_q4", {24'd0, bus.q}, 32'h02);
    checkOutput("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
